note_sample_player: RTL and testbench
=====================================

NOTE_SAMPLE_PLAYER -- requirements
Module: note_sample_player

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, ROM address width.
REQ-002 SHALL have parameter LAST_ADDR, default 16383, final sample address of the note loop.
REQ-003 SHALL have parameter RAMP_DIV, default 64, samples per envelope gain step (1..255).
REQ-004 SHALL have port CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port play  in  1  level request to sound the note; synchronous to CLOCK_50.
REQ-007 SHALL have port rom_addr  out  ADDR_W  sample ROM read address.
REQ-008 SHALL have port rom_q  in  10  signed two's-complement sample, valid the cycle after rom_addr is presented.
REQ-009 SHALL have port audio_out_allowed  in  1  audio controller output FIFO has space.
REQ-010 SHALL have port write_audio_out  out  1  one-cycle push strobe to audio controller.
REQ-011 SHALL have port left_channel_audio_out  out  32  left sample.
REQ-012 SHALL have port right_channel_audio_out  out  32  right sample, always equal to left.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, LOAD, PUSH.
REQ-015 IDLE: addr=0, gain=0, write_audio_out=0; play=1 -> FETCH next cycle.
REQ-016 FETCH: rom_addr=addr; -> LOAD next cycle unconditionally.
REQ-017 LOAD: capture rom_q, register scaled output (REQ-020); -> PUSH next cycle.
REQ-018 PUSH: write_audio_out = audio_out_allowed (combinational, only in PUSH); stay in PUSH while audio_out_allowed=0; on the cycle write_audio_out=1, advance addr, update envelope, then -> FETCH, or -> IDLE if releasing and new gain is 0.
REQ-019 addr increment SHALL wrap LAST_ADDR -> 0; no skipped or repeated address across wrap.
REQ-020 Output SHALL be (sample * gain) arithmetic-shifted right 4, gain unsigned 0..16, product 15-bit signed, result low 10 bits placed in bits [31:22], bits [21:0]=0.
REQ-021 Envelope: ramp counter counts pushed samples 0..RAMP_DIV-1; at each wrap to 0, gain +1 (saturate 16) when play=1, gain -1 (floor 0) when play=0.
REQ-022 gain=16 SHALL reproduce rom_q exactly; gain=0 SHALL output 0.
REQ-023 play deassert mid-note SHALL NOT stop immediately; playback continues from current addr while gain decays (release).
REQ-024 play reassert during release SHALL resume attack from current gain and addr, no addr reset.
REQ-025 Return to IDLE SHALL reset addr and ramp counter to 0 so the next note starts at sample 0.
REQ-026 Output registers SHALL hold value while stalled in PUSH.
REQ-027 At most one write_audio_out per sample; never asserted when audio_out_allowed=0.

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE, addr=0, gain=0, ramp counter=0, outputs 0, write_audio_out=0, busy=0, regardless of state or play.
REQ-029 reset SHALL take priority over every other event in the same cycle, including a pending push.

Verification
REQ-030 Reset 3 cycles, play=1, allowed=1, rom_q=addr-derived ramp -> first push at cycle 4 after play, left=0 (gain 0), one push every 3 cycles thereafter.
REQ-031 RAMP_DIV=1, rom_q=10'h1FF constant, play=1 -> left[31:22] sequence 31,63,...,511 after 16 pushes, then holds 10'h1FF.
REQ-032 allowed held 0 for 20 cycles in PUSH -> no strobe, outputs and rom_addr stable; allowed=1 -> exactly one strobe.
REQ-033 LAST_ADDR=7, play held -> rom_addr sequence 0..7,0,1 across wrap.
REQ-034 gain=16, drop play, RAMP_DIV=1 -> 16 more pushes with decaying gain, busy falls, addr=0; re-raise play at push 8 -> gain climbs from 8, addr continues.
REQ-035 Assert reset while stalled in PUSH with allowed=0 -> next cycle IDLE, all outputs 0, no strobe.

Source files
------------

// File: rtl/note_sample_player.sv
// note_sample_player: loops a sampled note out of a ROM into the audio
// controller FIFO. Each sample is fetched, scaled by an attack/release
// envelope gain (0..16 in 1/16 steps) and pushed once the FIFO has room.
module note_sample_player #(
   parameter int ADDR_W    = 14,
   parameter int LAST_ADDR = 16383,
   parameter int RAMP_DIV  = 64
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              play,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [9:0]        rom_q,
   input  logic              audio_out_allowed,
   output logic              write_audio_out,
   output logic [31:0]       left_channel_audio_out,
   output logic [31:0]       right_channel_audio_out,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [7:0]        RAMP_LAST = 8'(RAMP_DIV - 1);
   localparam logic [4:0]        GAIN_MAX  = 5'd16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_LOAD  = 2'd2,
      S_PUSH  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [4:0]        gain_q, gain_d;
   logic [7:0]        ramp_q, ramp_d;
   logic [9:0]        sample_q, sample_d;

   logic signed [14:0] sample_ext;
   logic signed [14:0] gain_ext;
   logic signed [14:0] product;
   logic [9:0]         scaled;
   logic               unused_product_bits;
   logic [4:0]         gain_step;

   // Scale the incoming sample by the current gain; >>>4 keeps gain 16 at unity.
   always_comb begin
      sample_ext          = {{5{rom_q[9]}}, rom_q};
      gain_ext            = {10'd0, gain_q};
      product             = sample_ext * gain_ext;
      scaled              = product[13:4];
      unused_product_bits = ^{product[14], product[3:0]};
   end

   // Envelope gain one ramp step on: rise toward 16 while held, decay toward 0 on release.
   always_comb begin
      gain_step = gain_q;
      if (play) begin
         if (gain_q != GAIN_MAX) gain_step = gain_q + 5'd1;
      end else begin
         if (gain_q != 5'd0) gain_step = gain_q - 5'd1;
      end
   end

   // State and datapath registers; reset wins over any pending push.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         gain_q   <= '0;
         ramp_q   <= '0;
         sample_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         gain_q   <= gain_d;
         ramp_q   <= ramp_d;
         sample_q <= sample_d;
      end
   end

   // Next-state and datapath update: fetch, load/scale, then wait for FIFO room.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      gain_d   = gain_q;
      ramp_d   = ramp_q;
      sample_d = sample_q;
      case (state_q)
         S_IDLE: begin
            addr_d   = '0;
            gain_d   = '0;
            ramp_d   = '0;
            sample_d = '0;
            if (play) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            sample_d = scaled;
            state_d  = S_PUSH;
         end
         S_PUSH: begin
            if (audio_out_allowed) begin
               addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
               if (ramp_q == RAMP_LAST) begin
                  ramp_d = '0;
                  gain_d = gain_step;
               end else begin
                  ramp_d = ramp_q + 8'd1;
               end
               state_d = S_FETCH;
               // Release finished: park at sample 0 so the next note starts clean.
               if (!play && (gain_d == 5'd0)) begin
                  state_d = S_IDLE;
                  addr_d  = '0;
                  ramp_d  = '0;
                  gain_d  = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs: strobe only in PUSH with FIFO room, never while reset is asserted.
   always_comb begin
      write_audio_out         = (state_q == S_PUSH) && audio_out_allowed && !reset;
      busy                    = (state_q != S_IDLE);
      rom_addr                = addr_q;
      left_channel_audio_out  = {sample_q, 22'd0};
      right_channel_audio_out = {sample_q, 22'd0};
   end

endmodule

// File: tb/tb_note_sample_player.sv
// tb_note_sample_player: directed checks of latency, envelope, wrap, stall and
// reset, then a randomized run, all scored against a sample-level model.
module tb_note_sample_player;

   localparam int ADDR_W    = 4;
   localparam int LAST_ADDR = 11;
   localparam int RAMP_DIV  = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              play;
   logic [ADDR_W-1:0] rom_addr;
   logic [9:0]        rom_q;
   logic              allowed;
   logic              write_audio_out;
   logic [31:0]       left_out;
   logic [31:0]       right_out;
   logic              busy;

   logic [9:0] rom_mem [0:15];

   int total = 0;
   int bad   = 0;

   // model state
   bit m_active = 1'b0;
   int m_addr   = 0;
   int m_gain   = 0;
   int m_ramp   = 0;
   int cyc      = 0;
   int ref_cyc  = 0;
   bit clean    = 1'b0;
   int push_cnt = 0;

   always #5 clk = ~clk;

   note_sample_player #(
      .ADDR_W   (ADDR_W),
      .LAST_ADDR(LAST_ADDR),
      .RAMP_DIV (RAMP_DIV)
   ) dut (
      .CLOCK_50               (clk),
      .reset                  (reset),
      .play                   (play),
      .rom_addr               (rom_addr),
      .rom_q                  (rom_q),
      .audio_out_allowed      (allowed),
      .write_audio_out        (write_audio_out),
      .left_channel_audio_out (left_out),
      .right_channel_audio_out(right_out),
      .busy                   (busy)
   );

   // synchronous sample ROM, one cycle read latency
   always @(posedge clk) rom_q <= rom_mem[rom_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // sample * gain / 16 (floor), low 10 bits in the top of the word
   function automatic logic [31:0] expected_word(input logic [9:0] s, input int g);
      int sample_val;
      int prod;
      int shifted;
      sample_val = (s >= 10'd512) ? int'(s) - 1024 : int'(s);
      prod       = sample_val * g;
      shifted    = prod >>> 4;
      return {shifted[9:0], 22'd0};
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 16; i++) rom_mem[i] = 10'($urandom);
      rom_mem[2] = 10'h200;
      rom_mem[3] = 10'h1FF;
   endtask

   task automatic fill_const(input logic [9:0] v);
      for (int i = 0; i < 16; i++) rom_mem[i] = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_push(input int bound, output int k);
      int start;
      start = push_cnt;
      k = 0;
      while (push_cnt == start && k < bound) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("push_seen", (push_cnt != start), 1);
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while (busy && k < bound) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("idle_reached", busy, 0);
   endtask

   // compare process: check the DUT against the model, then advance the model
   initial begin
      logic [31:0] exp_word;
      forever begin
         @(negedge clk);
         cyc++;
         check("busy", busy, m_active);
         if (write_audio_out) begin
            check("strobe_allowed", allowed, 1);
            check("strobe_reset", reset, 0);
         end
         if (reset) begin
            m_active = 1'b0;
            m_addr   = 0;
            m_gain   = 0;
            m_ramp   = 0;
         end else if (!m_active) begin
            if (play) begin
               m_active = 1'b1;
               ref_cyc  = cyc;
               clean    = 1'b1;
            end
         end else begin
            if (!allowed) clean = 1'b0;
            if (write_audio_out) begin
               exp_word = expected_word(rom_mem[m_addr], m_gain);
               check("push_left", left_out, exp_word);
               check("push_right", right_out, exp_word);
               check("push_addr", rom_addr, m_addr);
               if (clean) check("push_spacing", cyc - ref_cyc, 3);
               $display("push %0d addr=%0d gain=%0d left=%h", push_cnt, m_addr, m_gain, left_out);
               ref_cyc  = cyc;
               clean    = 1'b1;
               push_cnt++;
               m_addr = (m_addr == LAST_ADDR) ? 0 : m_addr + 1;
               m_ramp++;
               if (m_ramp == RAMP_DIV) begin
                  m_ramp = 0;
                  if (play) m_gain = (m_gain < 16) ? m_gain + 1 : 16;
                  else      m_gain = (m_gain > 0) ? m_gain - 1 : 0;
               end
               if (!play && m_gain == 0) begin
                  m_active = 1'b0;
                  m_addr   = 0;
                  m_ramp   = 0;
               end
            end
         end
      end
   end

   // stimulus
   initial begin
      int k;
      int n;
      int seg;
      int p0;
      logic [31:0]       l0;
      logic [ADDR_W-1:0] a0;

      fill_random();
      reset   = 1'b1;
      play    = 1'b0;
      allowed = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_write", write_audio_out, 0);
      check("reset_left", left_out, 0);
      check("reset_right", right_out, 0);
      check("reset_addr", rom_addr, 0);
      step();
      reset = 1'b0;
      step();

      // first-push latency, steady spacing and address wrap
      play = 1'b1;
      for (int i = 0; i < 14; i++) begin
         wait_push(12, k);
         check("push_latency", k, (i == 0) ? 4 : 3);
         check("wrap_addr", rom_addr, i % 12);
         if (i == 0) check("first_left", left_out, 0);
      end
      step();
      play = 1'b0;
      wait_idle(2000);
      check("idle_addr", rom_addr, 0);

      // attack to full scale on a constant sample, then complete release
      step();
      fill_const(10'h1FF);
      play = 1'b1;
      for (int j = 1; j <= 60; j++) begin
         wait_push(12, k);
         if (j == 1)  check("ramp_p1", left_out[31:22], 0);
         if (j == 4)  check("ramp_p4", left_out[31:22], 31);
         if (j == 7)  check("ramp_p7", left_out[31:22], 63);
         if (j == 49) check("ramp_p49", left_out[31:22], 511);
         if (j == 60) check("ramp_p60", left_out[31:22], 511);
      end
      step();
      play = 1'b0;
      n = 0;
      do begin
         wait_push(12, k);
         if (n == 0) check("release_first", left_out[31:22], 511);
         n++;
         step();
      end while (busy && n < 100);
      check("release_pushes", n, 48);
      check("release_addr", rom_addr, 0);

      // release interrupted by a new press: gain resumes from 8, addr continues
      play = 1'b1;
      for (int j = 0; j < 60; j++) wait_push(12, k);
      step();
      play = 1'b0;
      for (int j = 0; j < 25; j++) wait_push(12, k);
      step();
      play = 1'b1;
      wait_push(12, k);
      check("resume_gain8", left_out[31:22], 255);
      check("resume_addr", rom_addr, 1);
      wait_push(12, k);
      wait_push(12, k);
      check("resume_gain9", left_out[31:22], 287);
      step();
      play = 1'b0;
      wait_idle(3000);

      // stall in PUSH: outputs hold, no strobe, then exactly one strobe
      fill_random();
      step();
      play = 1'b1;
      for (int j = 0; j < 10; j++) wait_push(12, k);
      step();
      allowed = 1'b0;
      repeat (6) step();
      @(negedge clk);
      #1;
      l0 = left_out;
      a0 = rom_addr;
      p0 = push_cnt;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         #1;
         check("stall_strobe", write_audio_out, 0);
         check("stall_left", left_out, l0);
         check("stall_addr", rom_addr, a0);
      end
      step();
      allowed = 1'b1;
      step();
      allowed = 1'b0;
      repeat (8) step();
      check("single_strobe", push_cnt - p0, 1);

      // reset while stalled with a push pending
      reset   = 1'b1;
      allowed = 1'b1;
      play    = 1'b0;
      @(negedge clk);
      #1;
      check("reset_no_strobe", write_audio_out, 0);
      step();
      reset   = 1'b0;
      allowed = 1'b0;
      @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_left", left_out, 0);
      check("rst_right", right_out, 0);
      check("rst_addr", rom_addr, 0);
      check("rst_write", write_audio_out, 0);

      // randomized play/allowed/reset traffic
      fill_random();
      seg = 0;
      for (int c = 0; c < 4000; c++) begin
         step();
         allowed = ($urandom_range(0, 9) < 7);
         reset   = ($urandom_range(0, 799) == 0);
         if (seg == 0) begin
            play = ($urandom_range(0, 1) == 1);
            seg  = $urandom_range(10, 300);
         end else begin
            seg--;
         end
      end
      step();
      reset   = 1'b0;
      play    = 1'b0;
      allowed = 1'b1;
      wait_idle(3000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
